apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

APB3 completer (slave) holding a small control/status register bank: the responder side of the team's `apb_master`. It decodes APB transfers, inserts a run-time-programmable number of wait states, flags unmapped or read-only accesses with `apb_slverr`, and keeps a saturating error counter. It sits on the peripheral bus behind a master and drives the `reg_ctrl` field out to fabric logic.

## Interface
- `DBITS`, 16, data width (≥16).
- `ABITS`, 10, word-address width.
- `NREG`, 8, number of general RW registers (1..64).
- `ID_VAL`, 16'hA5B0, constant returned by the ID register.

Ports:
- `apb_clk` in 1: single clock.
- `apb_rst_n` in 1: asynchronous, active-low reset.
- `apb_sel` in 1: select.
- `apb_enable` in 1: access phase.
- `apb_write` in 1: 1 = write.
- `apb_addr` in ABITS: word address.
- `apb_wdata` in DBITS: write data.
- `apb_rdata` out DBITS: read data, valid while `apb_ready`=1.
- `apb_ready` out 1: transfer completes on the edge where ready=1.
- `apb_slverr` out 1: error response, valid while `apb_ready`=1.
- `reg_ctrl` out DBITS: live CTRL register.
- `err_pulse` out 1: one-cycle pulse per errored transfer.

## Operation
- Register map (word addresses):
  - 0 CTRL RW. Bits [3:0] = wait states W for subsequent transfers. Bit DBITS-1 = ERR_CNT clear; it self-clears and always reads 0.
  - 1 SCRATCH RW.
  - 2 ID RO, returns ID_VAL.
  - 3 ERR_CNT RO.
  - 4..3+NREG: GEN[i] RW.
- Error cases: address ≥ 4+NREG, or a write to 2 or 3. Response is slverr=1, rdata=0, no state change except ERR_CNT.
- ERR_CNT behaviour:
  - Increments by 1 at the completing edge of every errored transfer.
  - Saturates at all-ones.
  - Cleared to 0 by a write to CTRL with bit DBITS-1 set.
- State machine:
  - IDLE → SETUP on `sel & ~enable`.
  - SETUP → ACCESS unconditionally. Latch addr/write/wdata and W = CTRL[3:0].
  - ACCESS: stay while ready=0. The completing edge (ready=1) returns to IDLE.
  - Any state: `sel`=0 forces IDLE with ready=0. An aborted transfer performs no write and no count.
- Writes commit on the completing edge only. W is sampled at SETUP, so a CTRL write takes effect from the next transfer.

## Timing
- Reset values: `apb_ready`, `apb_slverr`, `err_pulse` = 0; `apb_rdata` = 0; CTRL, SCRATCH, GEN[*], ERR_CNT = 0. So `reg_ctrl`=0 and W=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Ready timing:
  - At the SETUP edge: load cnt=W and set ready ← (W==0).
  - In ACCESS with ready=0: cnt decrements, and ready ← (cnt==1).
  - At the completing edge: ready ← 0.
  - With W=0, ready is high in the first ACCESS cycle (zero wait). With W=n, ready is low for n ACCESS cycles.
- `apb_rdata` and `apb_slverr` are registered together with ready. They are 0 whenever ready=0.
- `err_pulse` is high for the single cycle after an errored completing edge.
- Reset asserted mid-transfer: outputs clear immediately and asynchronously. A partial write never commits.
- Back-to-back transfers: a new SETUP may directly follow the completing cycle.

## Structure
- Package `apb_slave_pkg` holds:
  - Address constants `A_CTRL`=0, `A_SCRATCH`=1, `A_ID`=2, `A_ERRCNT`=3, `A_GEN0`=4.
  - The state enum IDLE/SETUP/ACCESS.
  - The CTRL bit positions.
- One sub-module, `apb_sat_counter`: a DBITS-wide saturating counter with inc and clear inputs, used for ERR_CNT.

## Test plan
- Reset, then read 2 with W=0 → ready in the first ACCESS cycle, rdata=16'hA5B0, slverr=0.
- Write 16'h0003 to CTRL, then write 16'h1234 to 5 and read 5 back.
  - `reg_ctrl`=16'h0003 after the first transfer.
  - Ready is low for exactly 3 ACCESS cycles on each later transfer.
  - The read returns 16'h1234.
- Write to 3 and read from 4+NREG (12).
  - Both complete with slverr=1, rdata=0, and one `err_pulse` each.
  - ERR_CNT then reads 2.
- Write 16'h8000 to CTRL → ERR_CNT reads 0, CTRL reads 16'h0000.
- Drop `apb_sel` during a W=5 write to 1, then read 1 → original value retained, ready never asserted for the aborted transfer.
- Assert `apb_rst_n` low mid-ACCESS with W=4 → all outputs 0 immediately; after release, the next read of 0 returns 0.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared constants and types for the APB register-bank completer.
// Register map, bus phases and CTRL field layout.
package apb_slave_pkg;

  localparam int A_CTRL    = 0;
  localparam int A_SCRATCH = 1;
  localparam int A_ID      = 2;
  localparam int A_ERRCNT  = 3;
  localparam int A_GEN0    = 4;

  localparam int CTRL_W_LSB  = 0;
  localparam int CTRL_W_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  // The ERR_CNT clear strobe lives in the CTRL MSB.
  function automatic int ctrl_clr_bit(input int dbits);
    return dbits - 1;
  endfunction

endpackage

// File: rtl/apb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment.
module apb_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Count up, hold at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer with a control/status register bank.
// Programmable wait states, error response and error counter.
module apb_slave_regs
  import apb_slave_pkg::*;
#(
  parameter int               DBITS  = 16,
  parameter int               ABITS  = 10,
  parameter int               NREG   = 8,
  parameter logic [DBITS-1:0] ID_VAL = DBITS'(16'hA5B0)
) (
  input  logic             apb_clk,
  input  logic             apb_rst_n,
  input  logic             apb_sel,
  input  logic             apb_enable,
  input  logic             apb_write,
  input  logic [ABITS-1:0] apb_addr,
  input  logic [DBITS-1:0] apb_wdata,
  output logic [DBITS-1:0] apb_rdata,
  output logic             apb_ready,
  output logic             apb_slverr,
  output logic [DBITS-1:0] reg_ctrl,
  output logic             err_pulse
);

  localparam int CLR = ctrl_clr_bit(DBITS);
  localparam logic [DBITS-1:0] CLR_MASK = ~(DBITS'(1) << CLR);
  localparam logic [ABITS:0] LIMIT = (ABITS+1)'(A_GEN0 + NREG);

  state_e r_state, w_phase, w_next;

  logic                   r_ready, r_slverr, r_err_pulse;
  logic [DBITS-1:0]       r_rdata, r_ctrl, r_scratch, r_wdata;
  logic [DBITS-1:0]       r_gen [NREG];
  logic [ABITS-1:0]       r_addr;
  logic                   r_write;
  logic [CTRL_W_BITS-1:0] r_cnt;

  logic [DBITS-1:0]       w_errcnt, w_rd;
  logic [ABITS-1:0]       w_a;
  logic                   w_wr, w_err, w_fire;
  logic                   w_done, w_commit, w_inc, w_clr;
  logic [CTRL_W_BITS-1:0] w_wait;

  // Bus phase seen this cycle; r_state only ever holds IDLE or ACCESS.
  always_comb begin
    w_phase = IDLE;
    if (apb_sel) begin
      if (r_state == ACCESS)
        w_phase = ACCESS;
      else if (!apb_enable)
        w_phase = SETUP;
    end
  end

  // Next state from the current phase.
  always_comb begin
    w_next = IDLE;
    unique case (w_phase)
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = r_ready ? IDLE : ACCESS;
      default: w_next = IDLE;
    endcase
  end

  assign w_wait = r_ctrl[CTRL_W_LSB +: CTRL_W_BITS];
  assign w_a    = (w_phase == SETUP) ? apb_addr  : r_addr;
  assign w_wr   = (w_phase == SETUP) ? apb_write : r_write;

  assign w_err = ({1'b0, w_a} >= LIMIT) ||
                 (w_wr && ((w_a == ABITS'(A_ID)) ||
                           (w_a == ABITS'(A_ERRCNT))));

  assign w_fire = ((w_phase == SETUP) && (w_wait == '0)) ||
                  ((w_phase == ACCESS) && !r_ready &&
                   (r_cnt == CTRL_W_BITS'(1)));

  assign w_done   = (w_phase == ACCESS) && r_ready;
  assign w_commit = w_done && r_write && !r_slverr;
  assign w_inc    = w_done && r_slverr;
  assign w_clr    = w_commit && (r_addr == ABITS'(A_CTRL)) &&
                    r_wdata[CLR];

  // Read mux; errored accesses and writes return zero.
  always_comb begin
    w_rd = '0;
    if (!w_err && !w_wr) begin
      unique case (1'b1)
        (w_a == ABITS'(A_CTRL)):    w_rd = r_ctrl;
        (w_a == ABITS'(A_SCRATCH)): w_rd = r_scratch;
        (w_a == ABITS'(A_ID)):      w_rd = ID_VAL;
        (w_a == ABITS'(A_ERRCNT)):  w_rd = w_errcnt;
        default: begin
          for (int i = 0; i < NREG; i++)
            if (w_a == ABITS'(A_GEN0 + i))
              w_rd = r_gen[i];
        end
      endcase
    end
  end

  // Handshake: phase state, wait counter and registered response.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_slverr    <= 1'b0;
      r_rdata     <= '0;
      r_err_pulse <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next;
      r_ready     <= w_fire;
      r_slverr    <= w_fire && w_err;
      r_rdata     <= w_fire ? w_rd : '0;
      r_err_pulse <= w_inc;
      if (w_phase == SETUP) begin
        r_addr  <= apb_addr;
        r_write <= apb_write;
        r_wdata <= apb_wdata;
        r_cnt   <= w_wait;
      end else if ((w_phase == ACCESS) && !r_ready) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Register bank, written only on a clean completing edge.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_ctrl    <= '0;
      r_scratch <= '0;
      for (int i = 0; i < NREG; i++)
        r_gen[i] <= '0;
    end else if (w_commit) begin
      if (r_addr == ABITS'(A_CTRL))
        r_ctrl <= r_wdata & CLR_MASK;
      if (r_addr == ABITS'(A_SCRATCH))
        r_scratch <= r_wdata;
      for (int i = 0; i < NREG; i++)
        if (r_addr == ABITS'(A_GEN0 + i))
          r_gen[i] <= r_wdata;
    end
  end

  apb_sat_counter #(
    .W(DBITS)
  ) u_errcnt (
    .i_clk   (apb_clk),
    .i_rst_n (apb_rst_n),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_q     (w_errcnt)
  );

  assign apb_rdata  = r_rdata;
  assign apb_ready  = r_ready;
  assign apb_slverr = r_slverr;
  assign reg_ctrl   = r_ctrl;
  assign err_pulse  = r_err_pulse;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: directed steps plus random
// transfers checked against a register-map reference model.
module tb_apb_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [9:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata, reg_ctrl;
  logic        ready, slverr, err_pulse;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] m_ctrl, m_scr, m_err;
  logic [15:0] m_gen [8];

  always #5 clk = ~clk;

  apb_slave_regs dut (
    .apb_clk    (clk),
    .apb_rst_n  (rst_n),
    .apb_sel    (sel),
    .apb_enable (en),
    .apb_write  (wr),
    .apb_addr   (addr),
    .apb_wdata  (wdata),
    .apb_rdata  (rdata),
    .apb_ready  (ready),
    .apb_slverr (slverr),
    .reg_ctrl   (reg_ctrl),
    .err_pulse  (err_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_err(input int a, input bit w);
    return (a >= 12) || (w && (a == 2 || a == 3));
  endfunction

  function automatic logic [15:0] m_read(input int a);
    if (a == 0) return m_ctrl;
    if (a == 1) return m_scr;
    if (a == 2) return 16'hA5B0;
    if (a == 3) return m_err;
    if (a >= 4 && a < 12) return m_gen[a-4];
    return 16'h0000;
  endfunction

  task automatic m_reset();
    m_ctrl = 0;
    m_scr = 0;
    m_err = 0;
    for (int i = 0; i < 8; i++) m_gen[i] = 0;
  endtask

  task automatic m_apply(input int a, input bit w, input logic [15:0] d);
    if (m_is_err(a, w)) begin
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end else if (w) begin
      if (a == 0) begin
        m_ctrl = {1'b0, d[14:0]};
        if (d[15]) m_err = 0;
      end else if (a == 1) begin
        m_scr = d;
      end else begin
        m_gen[a-4] = d;
      end
    end
  endtask

  task automatic xfer(input string tag, input int a, input bit w,
                      input logic [15:0] d);
    int waits;
    int expw;
    bit experr;
    logic [15:0] expd;
    expw = int'(m_ctrl[3:0]);
    experr = m_is_err(a, w);
    expd = experr ? 16'h0000 : m_read(a);
    @(posedge clk); #1;
    sel = 1; en = 0; addr = 10'(a); wr = w; wdata = d;
    @(posedge clk); #1;
    en = 1;
    waits = 0;
    while (ready !== 1'b1 && waits <= 40) begin
      @(posedge clk); #1;
      waits++;
    end
    chk({tag, " waits"}, waits, expw);
    chk({tag, " slverr"}, slverr, experr);
    if (!w) chk({tag, " rdata"}, rdata, expd);
    @(posedge clk); #1;
    sel = 0; en = 0;
    m_apply(a, w, d);
    chk({tag, " ready_after"}, ready, 0);
    chk({tag, " err_pulse"}, err_pulse, experr);
    chk({tag, " reg_ctrl"}, reg_ctrl, m_ctrl);
    @(posedge clk); #1;
    chk({tag, " pulse_end"}, err_pulse, 0);
  endtask

  task automatic abort_wr(input int a, input logic [15:0] d, input int k);
    @(posedge clk); #1;
    sel = 1; en = 0; addr = 10'(a); wr = 1; wdata = d;
    @(posedge clk); #1;
    en = 1;
    for (int i = 0; i < k; i++) begin
      chk("abort ready", ready, 0);
      @(posedge clk); #1;
    end
    sel = 0; en = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort idle ready", ready, 0);
    end
  endtask

  initial begin
    int waits;
    int a;
    bit w;
    logic [15:0] d;
    m_reset();
    #2;
    chk("rst ready", ready, 0);
    chk("rst rdata", rdata, 0);
    chk("rst slverr", slverr, 0);
    chk("rst err_pulse", err_pulse, 0);
    chk("rst reg_ctrl", reg_ctrl, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    xfer("read id", 2, 0, 16'h0);
    xfer("ctrl w3", 0, 1, 16'h0003);
    xfer("wr gen1", 5, 1, 16'h1234);
    xfer("rd gen1", 5, 0, 16'h0);
    xfer("wr errcnt", 3, 1, 16'hFFFF);
    xfer("rd unmapped", 12, 0, 16'h0);
    xfer("rd errcnt2", 3, 0, 16'h0);
    xfer("ctrl clr", 0, 1, 16'h8000);
    xfer("rd errcnt0", 3, 0, 16'h0);
    xfer("rd ctrl0", 0, 0, 16'h0);

    xfer("scr seed", 1, 1, 16'h5555);
    xfer("ctrl w5", 0, 1, 16'h0005);
    abort_wr(1, 16'hDEAD, 3);
    xfer("rd scr kept", 1, 0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 13));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if (a == 0) d[3:0] = 4'($urandom_range(0, 3));
      xfer("rand", a, w, d);
    end

    xfer("ctrl w4", 0, 1, 16'h0004);
    @(posedge clk); #1;
    sel = 1; en = 0; addr = 10'd1; wr = 1; wdata = 16'hBEEF;
    @(posedge clk); #1;
    en = 1;
    waits = 0;
    while (ready !== 1'b1 && waits <= 40) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("pre-rst waits", waits, 4);
    #2 rst_n = 0;
    #1;
    chk("mid rst ready", ready, 0);
    chk("mid rst rdata", rdata, 0);
    chk("mid rst slverr", slverr, 0);
    chk("mid rst err_pulse", err_pulse, 0);
    chk("mid rst reg_ctrl", reg_ctrl, 0);
    sel = 0; en = 0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1;
    xfer("post rst ctrl", 0, 0, 16'h0);
    xfer("post rst scr", 1, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
